loadable_updown_counter: RTL and testbench

LOADABLE_UPDOWN_COUNTER -- requirements
Module: loadable_updown_counter

---
 rtl/counter_pkg.sv | 7 +
 rtl/counter_checker.sv | 8 +
 rtl/loadable_updown_counter.sv | 56 +++++
 tb/tb_loadable_updown_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: mode selectors and legal WIDTH range for loadable_updown_counter
package counter_pkg;
  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT = 1;
  localparam int CNT_WIDTH_MIN = 2;
  localparam int CNT_WIDTH_MAX = 32;
endpackage

// File: rtl/counter_checker.sv
// counter_checker: never-checker, fire[0] raised while test_expr holds outside reset
module counter_checker (
  input  logic       rst,
  input  logic       test_expr,
  output logic [0:0] fire
);
  assign fire[0] = !rst && test_expr;
endmodule

// File: rtl/loadable_updown_counter.sv
// loadable_updown_counter: load/up/down counter with sticky ovf/unf; CNT_OVL_CHECK_EN adds checkers on assert_fire
module loadable_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_flags,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf,
  output logic             assert_fire
);
  localparam bit SAT = SATURATE == CNT_MODE_SAT;
  logic [WIDTH-1:0] ld_val, nxt;
  logic up, dn;
  assign at_max = data_out == MAX_VAL;
  assign at_min = data_out == '0;
  // zero-extended compare keeps the clamp well-formed when MAX_VAL is all ones
  assign ld_val = {1'b0, data_in} > {1'b0, MAX_VAL} ? MAX_VAL : data_in;
  assign up = inc && !dec && !ld;
  assign dn = dec && !inc && !ld;
  always_comb
    nxt = ld ? ld_val
        : up ? (at_max ? (SAT ? MAX_VAL : '0) : data_out + WIDTH'(1))
        : dn ? (at_min ? (SAT ? '0 : MAX_VAL) : data_out - WIDTH'(1))
        : data_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_out <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      data_out <= nxt;
      ovf <= (up && at_max) || (ovf && !clr_flags);
      unf <= (dn && at_min) || (unf && !clr_flags);
    end
`ifdef CNT_OVL_CHECK_EN
  logic [0:0] fire_up, fire_dn, fire_rng;
  counter_checker u_chk_up (.rst(rst), .test_expr(inc && at_max && !ld), .fire(fire_up));
  counter_checker u_chk_dn (.rst(rst), .test_expr(dec && at_min && !ld), .fire(fire_dn));
  counter_checker u_chk_rng (.rst(rst), .test_expr({1'b0, data_out} > {1'b0, MAX_VAL}), .fire(fire_rng));
  assign assert_fire = fire_up[0] | fire_dn[0] | fire_rng[0];
`else
  assign assert_fire = 1'b0;
`endif
endmodule

// File: tb/tb_loadable_updown_counter.sv
// tb_loadable_updown_counter: scoreboard bench over WIDTH=3 wrap, WIDTH=4/MAX 9 saturate and WIDTH=8 wrap counters
module tb_loadable_updown_counter;
`ifdef CNT_OVL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct packed {
    logic [7:0] dout;
    logic amax, amin, ovf, unf, fire;
  } obs_t;
  logic clk = 0, rst = 1;
  logic ld_a = 0, inc_a = 0, dec_a = 0, clr_a = 0;
  logic ld_b = 0, inc_b = 0, dec_b = 0, clr_b = 0;
  logic ld_c = 0, inc_c = 0, dec_c = 0, clr_c = 0;
  logic [2:0] din_a = 0, dout_a;
  logic [3:0] din_b = 0, dout_b;
  logic [7:0] din_c = 0, dout_c;
  logic amax_a, amin_a, ovf_a, unf_a, fire_a;
  logic amax_b, amin_b, ovf_b, unf_b, fire_b;
  logic amax_c, amin_c, ovf_c, unf_c, fire_c;
  int checks = 0, errors = 0;
  obs_t sb[$];
  obs_t o, e;
  always #5 clk = ~clk;
  loadable_updown_counter #(.WIDTH(3)) u_a (
    .clk(clk), .rst(rst), .ld(ld_a), .inc(inc_a), .dec(dec_a), .clr_flags(clr_a), .data_in(din_a),
    .data_out(dout_a), .at_max(amax_a), .at_min(amin_a), .ovf(ovf_a), .unf(unf_a), .assert_fire(fire_a));
  loadable_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .ld(ld_b), .inc(inc_b), .dec(dec_b), .clr_flags(clr_b), .data_in(din_b),
    .data_out(dout_b), .at_max(amax_b), .at_min(amin_b), .ovf(ovf_b), .unf(unf_b), .assert_fire(fire_b));
  loadable_updown_counter #(.WIDTH(8)) u_c (
    .clk(clk), .rst(rst), .ld(ld_c), .inc(inc_c), .dec(dec_c), .clr_flags(clr_c), .data_in(din_c),
    .data_out(dout_c), .at_max(amax_c), .at_min(amin_c), .ovf(ovf_c), .unf(unf_c), .assert_fire(fire_c));

  task automatic test_reset();
    rst = 1;
    #3;
    sb.push_back('{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    sb.push_back('{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    sb.push_back('{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    o = {5'd0, dout_a, amax_a, amin_a, ovf_a, unf_a, fire_a};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_w3 got %h exp %h", o, e); end
    o = {4'd0, dout_b, amax_b, amin_b, ovf_b, unf_b, fire_b};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_w4 got %h exp %h", o, e); end
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_w8 got %h exp %h", o, e); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_wrap_w3();
    for (int i = 1; i <= 8; i++) begin
      inc_a = 1;
      sb.push_back('{8'(i % 8), i == 7, i == 8, i == 8, 1'b0, CHK && i == 7});
      @(posedge clk); #1;
      o = {5'd0, dout_a, amax_a, amin_a, ovf_a, unf_a, fire_a};
      e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_w3_inc%0d got %h exp %h", i, o, e); end
    end
    inc_a = 0;
  endtask

  task automatic test_saturate();
    logic [4:0] stim [5] = '{5'b1_1111, 5'b0_1000, 5'b0_0010, 5'b1_0000, 5'b0_0100};
    obs_t exp_t [5];
    exp_t[0] = '{8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[1] = '{8'd9, 1'b1, 1'b0, 1'b1, 1'b0, CHK};
    exp_t[2] = '{8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[3] = '{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t[4] = '{8'd0, 1'b0, 1'b1, 1'b0, 1'b1, CHK};
    for (int i = 0; i < 5; i++) begin
      ld_b = stim[i][4];
      din_b = stim[i][3:0] == 4'b1111 ? 4'd15 : 4'd0;
      inc_b = stim[i][3];
      clr_b = stim[i][1];
      dec_b = stim[i][2];
      sb.push_back(exp_t[i]);
      @(posedge clk); #1;
      o = {4'd0, dout_b, amax_b, amin_b, ovf_b, unf_b, fire_b};
      e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_w4_step%0d got %h exp %h", i, o, e); end
    end
    {ld_b, inc_b, dec_b, clr_b} = 0;
  endtask

  task automatic test_underflow_load();
    dec_c = 1;
    sb.push_back('{8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL unf_w8_dec got %h exp %h", o, e); end
    dec_c = 0; ld_c = 1; inc_c = 1; din_c = 5;
    sb.push_back('{8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL ld_w8_inc_ignored got %h exp %h", o, e); end
    ld_c = 0; inc_c = 0;
  endtask

  task automatic test_inc_dec_hold();
    ld_c = 1; din_c = 10; clr_c = 1;
    sb.push_back('{8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL ld10_clr got %h exp %h", o, e); end
    ld_c = 0; clr_c = 0; inc_c = 1; dec_c = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
      e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL incdec_hold%0d got %h exp %h", i, o, e); end
    end
    inc_c = 0; dec_c = 0;
  endtask

  task automatic test_clr_race_reset();
    ld_c = 1; din_c = 255;
    sb.push_back('{8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL ld255 got %h exp %h", o, e); end
    ld_c = 0; inc_c = 1; clr_c = 1;
    sb.push_back('{8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL ovf_beats_clr got %h exp %h", o, e); end
    clr_c = 0;
    sb.push_back('{8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL ovf_sticky got %h exp %h", o, e); end
    @(negedge clk);
    rst = 1;
    #1;
    sb.push_back('{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL async_rst got %h exp %h", o, e); end
    #1;
    rst = 0;
    inc_c = 0;
    sb.push_back('{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL rst_discard got %h exp %h", o, e); end
    inc_c = 1;
    sb.push_back('{8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
    e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL resume got %h exp %h", o, e); end
    inc_c = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] m = 1;
    logic mo = 0, mu = 0;
    for (int i = 0; i < 40; i++) begin
      ld_c = $urandom_range(0, 7) == 0;
      inc_c = $urandom_range(0, 1) == 1;
      dec_c = $urandom_range(0, 1) == 1;
      clr_c = $urandom_range(0, 5) == 0;
      din_c = $urandom_range(0, 3) == 0 ? 8'd254 : 8'($urandom_range(0, 3));
      if (clr_c) begin mo = 0; mu = 0; end
      if (ld_c) m = din_c;
      else if (inc_c && !dec_c) begin if (m == 8'd255) mo = 1; m = m + 8'd1; end
      else if (dec_c && !inc_c) begin if (m == 8'd0) mu = 1; m = m - 8'd1; end
      sb.push_back('{m, m == 8'd255, m == 8'd0, mo, mu,
                     CHK && !ld_c && ((inc_c && m == 8'd255) || (dec_c && m == 8'd0))});
      @(posedge clk); #1;
      o = {dout_c, amax_c, amin_c, ovf_c, unf_c, fire_c};
      e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_%0d got %h exp %h", i, o, e); end
    end
    {ld_c, inc_c, dec_c, clr_c} = 0;
  endtask

  initial begin
    test_reset();
    test_wrap_w3();
    test_saturate();
    test_underflow_load();
    test_inc_dec_hold();
    test_clr_race_reset();
    test_back_to_back();
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
